// File: rtl/liteeth_1rw1r_sram_ctrl.sv
// LiteEth 1RW+1R packet-buffer SRAM with clear sequencer and read pipeline.
// Build option: define SRAM_FWD_EN to forward RW writes to a colliding R read.
module liteeth_1rw1r_sram_ctrl #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 384,
  parameter int ADDR_WIDTH = 9,
  parameter int MASK_GRAN  = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                      clk0,
  input  logic                      rst,
  input  logic                      ce_rw1,
  input  logic                      we_in_rw1,
  input  logic [BITS/MASK_GRAN-1:0] w_mask_rw1,
  input  logic [ADDR_WIDTH-1:0]     addr_rw1,
  input  logic [BITS-1:0]           wd_in_rw1,
  output logic [BITS-1:0]           rd_out_rw1,
  output logic                      rd_valid_rw1,
  input  logic                      ce_r1,
  input  logic [ADDR_WIDTH-1:0]     addr_r1,
  output logic [BITS-1:0]           rd_out_r1,
  output logic                      rd_valid_r1,
  output logic                      init_busy,
  output logic                      err_addr
);

  localparam int LANES = BITS / MASK_GRAN;
  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(WORD_DEPTH - 1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [BITS-1:0]       mem [WORD_DEPTH];

  logic            run;
  logic            rw_in;
  logic            r_in;
  logic            wr_en;
  logic [BITS-1:0] bmask;
  logic [BITS-1:0] rw_old;
  logic [BITS-1:0] r_old;
  logic [BITS-1:0] merged;
  logic [BITS-1:0] r_data;

  assign run       = (state == S_RUN);
  assign init_busy = (state == S_INIT);
  assign rw_in     = {1'b0, addr_rw1} < DEPTH;
  assign r_in      = {1'b0, addr_r1} < DEPTH;
  assign wr_en     = run & ce_rw1 & we_in_rw1 & rw_in;

  always_comb begin
    bmask = '0;
    for (int k = 0; k < LANES; k++) begin
      bmask[k*MASK_GRAN +: MASK_GRAN] =
        {MASK_GRAN{w_mask_rw1[k]}};
    end
  end

  always_comb begin
    rw_old = '0;
    if (rw_in) rw_old = mem[addr_rw1];
  end

  always_comb begin
    r_old = '0;
    if (r_in) r_old = mem[addr_r1];
  end

  assign merged = (wd_in_rw1 & bmask) | (rw_old & ~bmask);

`ifdef SRAM_FWD_EN
  logic hit;
  assign hit = wr_en & r_in & (addr_r1 == addr_rw1);
  assign r_data = hit ? merged : r_old;
`else
  assign r_data = r_old;
`endif

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state   <= S_INIT;
      clr_ptr <= '0;
    end else begin
      unique case (1'b1)
        (state == S_INIT): begin
          if (clr_ptr == LAST) begin
            state   <= S_RUN;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Array itself is never reset; the sequencer zeroes it instead.
  always_ff @(posedge clk0) begin
    if (!run) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      mem[addr_rw1] <= merged;
    end
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      err_addr <= 1'b0;
    end else if (run & ((ce_rw1 & ~rw_in) |
                        (ce_r1 & ~r_in))) begin
      err_addr <= 1'b1;
    end
  end

  logic            v1_rw;
  logic            v1_r;
  logic [BITS-1:0] d1_rw;
  logic [BITS-1:0] d1_r;

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      v1_rw <= 1'b0;
      v1_r  <= 1'b0;
      d1_rw <= '0;
      d1_r  <= '0;
    end else begin
      v1_rw <= run & ce_rw1;
      v1_r  <= run & ce_r1;
      if (run & ce_rw1) d1_rw <= rw_old;
      if (run & ce_r1)  d1_r  <= r_data;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic            v2_rw;
      logic            v2_r;
      logic [BITS-1:0] d2_rw;
      logic [BITS-1:0] d2_r;

      always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
          v2_rw <= 1'b0;
          v2_r  <= 1'b0;
          d2_rw <= '0;
          d2_r  <= '0;
        end else begin
          v2_rw <= v1_rw;
          v2_r  <= v1_r;
          if (v1_rw) d2_rw <= d1_rw;
          if (v1_r)  d2_r  <= d1_r;
        end
      end

      assign rd_valid_rw1 = v2_rw;
      assign rd_valid_r1  = v2_r;
      assign rd_out_rw1   = d2_rw;
      assign rd_out_r1    = d2_r;
    end else begin : g_lat1
      assign rd_valid_rw1 = v1_rw;
      assign rd_valid_r1  = v1_r;
      assign rd_out_rw1   = d1_rw;
      assign rd_out_r1    = d1_r;
    end
  endgenerate

endmodule

// File: tb/tb_liteeth_1rw1r_sram_ctrl.sv
// Bench for liteeth_1rw1r_sram_ctrl: array model, random and directed traffic.
// Collision expectation follows SRAM_FWD_EN when defined.
module tb_liteeth_1rw1r_sram_ctrl;

`ifdef SRAM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 384;

  logic        clk0 = 1'b0;
  logic        rst = 1'b1;
  logic        ce_rw1 = 1'b0;
  logic        we_in_rw1 = 1'b0;
  logic [3:0]  w_mask_rw1 = '0;
  logic [8:0]  addr_rw1 = '0;
  logic [31:0] wd_in_rw1 = '0;
  logic        ce_r1 = 1'b0;
  logic [8:0]  addr_r1 = '0;

  logic [31:0] rd_out_rw1, rd_out_r1;
  logic        rd_valid_rw1, rd_valid_r1;
  logic        init_busy, err_addr;

  logic [31:0] b_out_rw1, b_out_r1;
  logic        b_valid_rw1, b_valid_r1;
  logic        b_busy, b_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [DEPTH];
  logic [31:0] exp_rw, exp_r;
  logic        exp_vrw, exp_vr, exp_err;

  always #5 clk0 = ~clk0;

  liteeth_1rw1r_sram_ctrl dut (
    .clk0(clk0), .rst(rst),
    .ce_rw1(ce_rw1), .we_in_rw1(we_in_rw1),
    .w_mask_rw1(w_mask_rw1), .addr_rw1(addr_rw1),
    .wd_in_rw1(wd_in_rw1), .rd_out_rw1(rd_out_rw1),
    .rd_valid_rw1(rd_valid_rw1), .ce_r1(ce_r1),
    .addr_r1(addr_r1), .rd_out_r1(rd_out_r1),
    .rd_valid_r1(rd_valid_r1), .init_busy(init_busy),
    .err_addr(err_addr)
  );

  liteeth_1rw1r_sram_ctrl #(.RD_LAT(2)) dut2 (
    .clk0(clk0), .rst(rst),
    .ce_rw1(ce_rw1), .we_in_rw1(we_in_rw1),
    .w_mask_rw1(w_mask_rw1), .addr_rw1(addr_rw1),
    .wd_in_rw1(wd_in_rw1), .rd_out_rw1(b_out_rw1),
    .rd_valid_rw1(b_valid_rw1), .ce_r1(ce_r1),
    .addr_r1(addr_r1), .rd_out_r1(b_out_r1),
    .rd_valid_r1(b_valid_r1), .init_busy(b_busy),
    .err_addr(b_err)
  );

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    exp_rw = '0; exp_r = '0;
    exp_vrw = 1'b0; exp_vr = 1'b0; exp_err = 1'b0;
  endtask

  // One request cycle; model computes expected outputs from plain rules.
  task automatic step(input logic crw, input logic we,
                      input logic [3:0] m, input logic [8:0] a,
                      input logic [31:0] d, input logic cr,
                      input logic [8:0] ra);
    logic [31:0] old, bm, nw;
    ce_rw1 = crw; we_in_rw1 = we; w_mask_rw1 = m;
    addr_rw1 = a; wd_in_rw1 = d; ce_r1 = cr; addr_r1 = ra;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    old = '0;
    if (a < DEPTH) old = mm[a];
    nw = (d & bm) | (old & ~bm);
    if (crw) exp_rw = old;
    exp_vrw = crw;
    if (cr) begin
      if (ra >= DEPTH) exp_r = '0;
      else if (FWD && crw && we && a == ra) exp_r = nw;
      else exp_r = mm[ra];
    end
    exp_vr = cr;
    if ((crw && a >= DEPTH) || (cr && ra >= DEPTH)) exp_err = 1'b1;
    if (crw && we && a < DEPTH) mm[a] = nw;
    @(posedge clk0); #1;
    ce_rw1 = 1'b0; we_in_rw1 = 1'b0; ce_r1 = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    int bad = 0;
    ce_rw1 = 1'b1; we_in_rw1 = 1'b1; w_mask_rw1 = 4'hF;
    addr_rw1 = 9'd400; wd_in_rw1 = 32'hFFFF_FFFF;
    ce_r1 = 1'b1; addr_r1 = 9'd450;
    while (init_busy && n < 1000) begin
      @(posedge clk0); #1;
      n++;
      if (rd_valid_rw1 || rd_valid_r1 || err_addr) bad++;
    end
    ce_rw1 = 1'b0; we_in_rw1 = 1'b0; ce_r1 = 1'b0;
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL %s_init_len got %0d want %0d", tag, n, DEPTH);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_init_ignore got %0d bad cycles want 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    checks++;
    if ({init_busy, rd_valid_rw1, rd_valid_r1, err_addr} !== 4'b1000 ||
        rd_out_rw1 !== '0 || rd_out_r1 !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b vrw=%b vr=%b err=%b want 1000",
               init_busy, rd_valid_rw1, rd_valid_r1, err_addr);
    end
    rst = 1'b0;
    model_reset();
    wait_init("reset");
    for (int i = 0; i < 3; i++) begin
      logic [8:0] a;
      a = (i == 0) ? 9'd0 : (i == 1) ? 9'd200 : 9'd383;
      step(1'b1, 1'b0, 4'h0, a, '0, 1'b1, a);
      checks++;
      if (rd_out_rw1 !== 32'h0 || rd_valid_rw1 !== 1'b1 ||
          rd_out_r1 !== 32'h0 || rd_valid_r1 !== 1'b1) begin
        errors++;
        $display("FAIL clear_read addr %0d got rw=%h/%b r=%h/%b want 0/1",
                 a, rd_out_rw1, rd_valid_rw1, rd_out_r1, rd_valid_r1);
      end
    end
  endtask

  task automatic test_mask();
    step(1'b1, 1'b1, 4'hF, 9'd10, 32'hFFFF_FFFF, 1'b0, '0);
    step(1'b1, 1'b1, 4'b0101, 9'd10, 32'h1234_5678, 1'b0, '0);
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 9'd10);
    checks++;
    if (rd_out_r1 !== 32'hFF34_FF78 || rd_valid_r1 !== 1'b1) begin
      errors++;
      $display("FAIL mask_merge got %h/%b want ff34ff78/1",
               rd_out_r1, rd_valid_r1);
    end
  endtask

  task automatic test_collision();
    logic [31:0] want;
    want = FWD ? 32'hA5A5_A5A5 : 32'h0;
    step(1'b1, 1'b1, 4'hF, 9'd5, 32'hA5A5_A5A5, 1'b1, 9'd5);
    checks++;
    if (rd_out_r1 !== want || rd_valid_r1 !== 1'b1) begin
      errors++;
      $display("FAIL collision_r got %h want %h", rd_out_r1, want);
    end
    checks++;
    if (rd_out_rw1 !== 32'h0 || rd_valid_rw1 !== 1'b1) begin
      errors++;
      $display("FAIL collision_rw got %h want 00000000", rd_out_rw1);
    end
  endtask

  task automatic test_oob();
    step(1'b1, 1'b1, 4'hF, 9'd16, 32'h0BAD_F00D, 1'b0, '0);
    checks++;
    if (err_addr !== 1'b0) begin
      errors++;
      $display("FAIL oob_pre_err got %b want 0", err_addr);
    end
    step(1'b1, 1'b1, 4'hF, 9'd400, 32'hDEAD_BEEF, 1'b0, '0);
    checks++;
    if (err_addr !== 1'b1) begin
      errors++;
      $display("FAIL oob_err got %b want 1", err_addr);
    end
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 9'd400);
    checks++;
    if (rd_out_r1 !== 32'h0 || rd_valid_r1 !== 1'b1) begin
      errors++;
      $display("FAIL oob_read got %h/%b want 0/1", rd_out_r1, rd_valid_r1);
    end
    step(1'b1, 1'b0, 4'h0, 9'd16, '0, 1'b0, '0);
    checks++;
    if (rd_out_rw1 !== 32'h0BAD_F00D || err_addr !== 1'b1) begin
      errors++;
      $display("FAIL oob_alias got %h err=%b want 0badf00d err=1",
               rd_out_rw1, err_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [8:0] a, ra;
      a  = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(380, 511))
                                        : 9'($urandom_range(0, 15));
      ra = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(380, 511))
                                        : 9'($urandom_range(0, 15));
      step(1'($urandom), 1'($urandom), 4'($urandom), a,
           $urandom, 1'($urandom), ra);
      checks++;
      if (rd_out_rw1 !== exp_rw || rd_valid_rw1 !== exp_vrw) begin
        errors++;
        $display("FAIL rand_rw #%0d got %h/%b want %h/%b",
                 i, rd_out_rw1, rd_valid_rw1, exp_rw, exp_vrw);
      end
      checks++;
      if (rd_out_r1 !== exp_r || rd_valid_r1 !== exp_vr) begin
        errors++;
        $display("FAIL rand_r #%0d got %h/%b want %h/%b",
                 i, rd_out_r1, rd_valid_r1, exp_r, exp_vr);
      end
      checks++;
      if (err_addr !== exp_err) begin
        errors++;
        $display("FAIL rand_err #%0d got %b want %b", i, err_addr, exp_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [31:0] prev;
    logic [31:0] wd;
    logic        wv;
    for (int i = 0; i < 3; i++) begin
      vals[i] = $urandom;
      step(1'b1, 1'b1, 4'hF, 9'(i + 1), vals[i], 1'b0, '0);
    end
    prev = exp_r;
    for (int i = 0; i < 6; i++) begin
      ce_r1 = (i < 3);
      addr_r1 = 9'(i + 1);
      @(posedge clk0); #1;
      wv = (i >= 1 && i <= 3);
      wd = (i == 0) ? prev : vals[(i > 3) ? 2 : i - 1];
      checks++;
      if (b_valid_r1 !== wv || b_out_r1 !== wd) begin
        errors++;
        $display("FAIL lat2_cycle %0d got %h/%b want %h/%b",
                 i, b_out_r1, b_valid_r1, wd, wv);
      end
    end
    ce_r1 = 1'b0;
    exp_r = vals[2];
    exp_vr = 1'b0;
  endtask

  task automatic test_midinit_reset();
    step(1'b1, 1'b1, 4'hF, 9'd7, 32'hC0DE_0007, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk0); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk0);
    #1;
    checks++;
    if (init_busy !== 1'b1) begin
      errors++;
      $display("FAIL midinit_busy got %b want 1", init_busy);
    end
    rst = 1'b1;
    @(posedge clk0); #1;
    rst = 1'b0;
    model_reset();
    wait_init("midinit");
    step(1'b1, 1'b0, 4'h0, 9'd7, '0, 1'b0, '0);
    checks++;
    if (rd_out_rw1 !== 32'h0 || rd_valid_rw1 !== 1'b1 ||
        err_addr !== 1'b0) begin
      errors++;
      $display("FAIL midinit_read got %h/%b err=%b want 0/1 err=0",
               rd_out_rw1, rd_valid_rw1, err_addr);
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_collision();
    test_oob();
    test_random();
    test_back_to_back();
    test_midinit_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
